svfloat_div_seq: RTL and testbench

- Sequential floating-point divider front end. Takes two packed floats a/b, handles IEEE special cases, pre-normalizes subnormals, and runs a bit-serial restoring mantissa division.
- Emits an unpacked result on valid/ready: sign, unbiased exponent, fixed-point mantissa with `width-1` fraction bits, plus inf/nan/zero overrides.
- Sits directly upstream of svfloat_packer, instantiated there with `frac = width-1`.

---
 rtl/svfloat_pkg.sv | 21 ++
 rtl/svfloat_div_step.sv | 24 ++
 rtl/svfloat_msb.sv | 17 +
 rtl/svfloat_div_seq.sv | 194 +++++++++++++++++++
 tb/tb_svfloat_div_seq.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/svfloat_pkg.sv
// rtl/svfloat_pkg.sv - shared float types, field helpers and divider state encoding
package svfloat;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float32;

  localparam int F32_EXP_WIDTH = 8;
  localparam int F32_MAN_WIDTH = 23;
  localparam int F32_BIAS      = 127;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DIV,
    DONE
  } div_state_e;

endpackage

// File: rtl/svfloat_div_step.sv
// rtl/svfloat_div_step.sv - one combinational restoring-division step
module svfloat_div_step #(
  parameter int mw = 24,
  parameter int rw = 25
) (
  input  logic [rw-1:0] rem,
  input  logic [mw-1:0] divisor,
  input  logic          first,
  output logic [rw-1:0] rem_next,
  output logic          q_bit
);

  logic [rw-1:0] partial;
  logic [rw:0]   diff;

  // After the first step rem < divisor, so its top bit is always clear and can be shifted out.
  always_comb begin
    partial  = first ? rem : {rem[rw-2:0], 1'b0};
    diff     = {1'b0, partial} - {{(rw + 1 - mw){1'b0}}, divisor};
    q_bit    = ~diff[rw];
    rem_next = q_bit ? diff[rw-1:0] : partial;
  end

endmodule

// File: rtl/svfloat_msb.sv
// rtl/svfloat_msb.sv - index of the highest set bit, used to pre-normalize subnormals
module svfloat_msb #(
  parameter int width = 23,
  parameter int iw    = $clog2(width + 1)
) (
  input  logic [width-1:0] value,
  output logic [iw-1:0]    msb
);

  always_comb begin
    msb = '0;
    for (int i = 0; i < width; i++) begin
      if (value[i]) msb = iw'(i);
    end
  end

endmodule

// File: rtl/svfloat_div_seq.sv
// rtl/svfloat_div_seq.sv - sequential float divider front end, unpacked result output
// SVFLOAT_DIV_RADIX4_EN chains two restoring steps per DIV cycle.
module svfloat_div_seq
  import svfloat::*;
#(
  parameter type float  = float32,
  parameter int  ewidth = 10,
  parameter int  width  = 26
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  float                     a,
  input  float                     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     is_inf,
  output logic                     is_nan,
  output logic                     is_zero,
  output logic                     d_sign,
  output logic signed [ewidth-1:0] d_exp,
  output logic [width-1:0]         d_man
);

  localparam int exp_w = $bits(a.exponent);
  localparam int man_w = $bits(a.mantissa);
  localparam int m_w   = man_w + 1;
  localparam int rem_w = man_w + 2;
  localparam int msb_w = $clog2(man_w + 1);
  localparam int cnt_w = $clog2(width + 1);
  localparam int bias  = (1 << (exp_w - 1)) - 1;

  localparam logic signed [ewidth-1:0] bias_e     = ewidth'(bias);
  localparam logic signed [ewidth-1:0] sub_base_e = ewidth'(1 - bias);
  localparam logic [msb_w-1:0]         man_top    = msb_w'(man_w);
  localparam logic [cnt_w-1:0]         cnt_full   = cnt_w'(width);

  div_state_e state, state_nxt;

  logic [exp_w-1:0]         a_exp_r, b_exp_r;
  logic [man_w-1:0]         a_man_r, b_man_r;
  logic [m_w-1:0]           mb;
  logic signed [ewidth-1:0] ea, eb;
  logic [rem_w-1:0]         rem;
  logic [width-2:0]         q;
  logic [cnt_w-1:0]         count;

  logic a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic sp_nan, sp_inf, sp_zero, special, accept;

  assign a_max   = &a.exponent;
  assign b_max   = &b.exponent;
  assign a_nan   = a_max & (|a.mantissa);
  assign b_nan   = b_max & (|b.mantissa);
  assign a_inf   = a_max & ~(|a.mantissa);
  assign b_inf   = b_max & ~(|b.mantissa);
  assign a_zero  = ~(|a.exponent) & ~(|a.mantissa);
  assign b_zero  = ~(|b.exponent) & ~(|b.mantissa);
  assign sp_nan  = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
  assign sp_inf  = ~sp_nan & (a_inf | b_zero);
  assign sp_zero = ~sp_nan & ~sp_inf & (a_zero | b_inf);
  assign special = sp_nan | sp_inf | sp_zero;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  // Subnormals are shifted so their leading one lands on the hidden-bit position.
  function automatic logic [m_w-1:0] norm_man(input logic [exp_w-1:0] expo,
                                              input logic [man_w-1:0] man,
                                              input logic [msb_w-1:0] msb);
    if (expo != '0) return {1'b1, man};
    return {1'b0, man} << (man_top - msb);
  endfunction

  function automatic logic signed [ewidth-1:0] norm_exp(input logic [exp_w-1:0] expo,
                                                        input logic [msb_w-1:0] msb);
    if (expo != '0) return $signed({{(ewidth - exp_w){1'b0}}, expo}) - bias_e;
    return sub_base_e - $signed({{(ewidth - msb_w){1'b0}}, man_top - msb});
  endfunction

  logic [msb_w-1:0] a_msb, b_msb;

  svfloat_msb #(.width(man_w), .iw(msb_w)) u_msb_a (.value(a_man_r), .msb(a_msb));
  svfloat_msb #(.width(man_w), .iw(msb_w)) u_msb_b (.value(b_man_r), .msb(b_msb));

  logic             first, last, bit1;
  logic [rem_w-1:0] rem1, rem_nxt;
  logic [width-1:0] q_nxt;
  logic [cnt_w-1:0] cnt_nxt;

  assign first = (count == cnt_full);

  svfloat_div_step #(.mw(m_w), .rw(rem_w)) u_step0 (
    .rem(rem), .divisor(mb), .first(first), .rem_next(rem1), .q_bit(bit1)
  );

`ifdef SVFLOAT_DIV_RADIX4_EN
  logic             bit2, dual;
  logic [rem_w-1:0] rem2;

  svfloat_div_step #(.mw(m_w), .rw(rem_w)) u_step1 (
    .rem(rem1), .divisor(mb), .first(1'b0), .rem_next(rem2), .q_bit(bit2)
  );

  // An odd step count leaves a single step for the final cycle.
  always_comb begin
    dual    = (count >= cnt_w'(2));
    q_nxt   = dual ? {q[width-3:0], bit1, bit2} : {q, bit1};
    rem_nxt = dual ? rem2 : rem1;
    cnt_nxt = count - (dual ? cnt_w'(2) : cnt_w'(1));
    last    = (count <= cnt_w'(2));
  end
`else
  always_comb begin
    q_nxt   = {q, bit1};
    rem_nxt = rem1;
    cnt_nxt = count - cnt_w'(1);
    last    = (count == cnt_w'(1));
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = special ? DONE : NORM;
      NORM:    state_nxt = DIV;
      DIV:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_exp_r <= '0;
      b_exp_r <= '0;
      a_man_r <= '0;
      b_man_r <= '0;
      mb      <= '0;
      ea      <= '0;
      eb      <= '0;
      rem     <= '0;
      q       <= '0;
      count   <= '0;
      is_inf  <= 1'b0;
      is_nan  <= 1'b0;
      is_zero <= 1'b0;
      d_sign  <= 1'b0;
      d_exp   <= '0;
      d_man   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_exp_r <= a.exponent;
          b_exp_r <= b.exponent;
          a_man_r <= a.mantissa;
          b_man_r <= b.mantissa;
          is_nan  <= sp_nan;
          is_inf  <= sp_inf;
          is_zero <= sp_zero;
          d_sign  <= a.sign ^ b.sign;
          d_exp   <= '0;
          d_man   <= '0;
        end
        NORM: begin
          rem   <= {1'b0, norm_man(a_exp_r, a_man_r, a_msb)};
          mb    <= norm_man(b_exp_r, b_man_r, b_msb);
          ea    <= norm_exp(a_exp_r, a_msb);
          eb    <= norm_exp(b_exp_r, b_msb);
          q     <= '0;
          count <= cnt_full;
        end
        DIV: begin
          rem   <= rem_nxt;
          q     <= q_nxt[width-2:0];
          count <= cnt_nxt;
          if (last) begin
            d_man <= {q_nxt[width-1:1], q_nxt[0] | (|rem_nxt)};
            d_exp <= ea - eb;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_svfloat_div_seq.sv
// tb/tb_svfloat_div_seq.sv - scoreboard bench for svfloat_div_seq against an arithmetic reference
module tb_svfloat_div_seq;

  localparam int W  = 26;
  localparam int EW = 10;
`ifdef SVFLOAT_DIV_RADIX4_EN
  localparam int LAT = (W + 1) / 2 + 2;
`else
  localparam int LAT = W + 2;
`endif

  typedef struct {
    bit     nan;
    bit     inf;
    bit     zero;
    bit     sign;
    int     e;
    longint man;
    int     lat;
    int     acc;
  } exp_t;

  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [31:0] a = 0, b = 0;
  logic in_ready, out_valid, is_inf, is_nan, is_zero, d_sign;
  logic signed [EW-1:0] d_exp;
  logic [W-1:0] d_man;

  int checks = 0, errors = 0, cycle = 0;
  exp_t exp_q[$];
  exp_t cur;
  bit pending = 0, release_chk = 0;
  int stall = 0, stall_next = 0;
  logic [W-1:0] h_man;
  logic signed [EW-1:0] h_exp;
  logic [3:0] h_flags;

  svfloat_div_seq #(.ewidth(EW), .width(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .is_inf(is_inf), .is_nan(is_nan), .is_zero(is_zero),
    .d_sign(d_sign), .d_exp(d_exp), .d_man(d_man)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void decode(input logic [31:0] x, output longint m, output int e);
    if (x[30:23] != 0) begin
      m = longint'(x[22:0]) + (longint'(1) << 23);
      e = int'(x[30:23]) - 127;
    end else begin
      m = longint'(x[22:0]);
      e = -126;
      while (m < (longint'(1) << 23)) begin
        m = m * 2;
        e = e - 1;
      end
    end
  endfunction

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    bit xn, xi, xz, yn, yi, yz;
    longint mx, my, num;
    int ex, ey;
    r = '{default: 0};
    r.sign = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    xz = (x[30:0] == 0);
    yz = (y[30:0] == 0);
    if (xn || yn || (xz && yz) || (xi && yi)) r.nan = 1;
    else if (xi || yz) r.inf = 1;
    else if (xz || yi) r.zero = 1;
    else begin
      decode(x, mx, ex);
      decode(y, my, ey);
      num   = mx * (longint'(1) << (W - 1));
      r.e   = ex - ey;
      r.man = (num / my) | ((num % my) != 0 ? 1 : 0);
    end
    return r;
  endfunction

  function automatic exp_t mk(input bit nan, input bit inf, input bit zero, input bit sign,
                              input int e, input longint man);
    exp_t r;
    r = '{default: 0};
    r.nan = nan; r.inf = inf; r.zero = zero; r.sign = sign; r.e = e; r.man = man;
    return r;
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] r;
    int k;
    k = $urandom_range(0, 11);
    r[31]    = 1'($urandom_range(0, 1));
    r[22:0]  = 23'($urandom);
    r[30:23] = 8'($urandom_range(1, 254));
    case (k)
      0:    r[30:0] = '0;
      1:    begin r[30:23] = 8'hFF; r[22:0] = '0; end
      2:    begin r[30:23] = 8'hFF; r[0] = 1'b1; end
      3, 4: begin r[30:23] = 8'h00; if (r[22:0] == 0) r[5] = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input exp_t e);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready stayed low for %0d cycles", guard);
      return;
    end
    a = x;
    b = y;
    in_valid = 1;
    @(posedge clk);
    #1;
    e.lat = (e.nan || e.inf || e.zero) ? 1 : LAT;
    e.acc = cycle;
    exp_q.push_back(e);
    in_valid = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (release_chk) begin
        chk("in_ready_after_release", in_ready, 1);
        release_chk = 0;
      end
      if (out_valid) begin
        if (!pending) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: out_valid=1 with no operand outstanding");
          end else begin
            cur = exp_q.pop_front();
            chk("is_nan", is_nan, cur.nan);
            chk("is_inf", is_inf, cur.inf);
            chk("is_zero", is_zero, cur.zero);
            chk("d_sign", d_sign, cur.sign);
            chk("d_exp", d_exp, cur.e);
            chk("d_man", d_man, cur.man);
            chk("latency", cycle - cur.acc + 1, cur.lat);
          end
          h_man = d_man;
          h_exp = d_exp;
          h_flags = {is_nan, is_inf, is_zero, d_sign};
          pending = 1;
          stall = stall_next;
          stall_next = 0;
        end else begin
          chk("hold_d_man", d_man, h_man);
          chk("hold_d_exp", d_exp, h_exp);
          chk("hold_flags", {is_nan, is_inf, is_zero, d_sign}, h_flags);
          chk("hold_in_ready", in_ready, 0);
        end
        if (stall > 0) begin
          out_ready = 0;
          stall--;
        end else begin
          out_ready = ($urandom_range(0, 2) != 0);
        end
        if (out_ready) begin
          pending = 0;
          release_chk = 1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    logic [31:0] x, y;
    int guard;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_flags", {is_nan, is_inf, is_zero, d_sign}, 0);
    chk("reset_d_exp", d_exp, 0);
    chk("reset_d_man", d_man, 0);
    rst_n = 1;

    stall_next = 5;
    issue(32'h40C00000, 32'h40000000, mk(0, 0, 0, 0, 1, 64'h3000000));
    issue(32'h3F800000, 32'h40400000, mk(0, 0, 0, 0, -1, 64'h1555555));
    issue(32'h3F800000, 32'h00000000, mk(0, 1, 0, 0, 0, 0));
    issue(32'h00000000, 32'h00000000, mk(1, 0, 0, 0, 0, 0));
    issue(32'hC0000000, 32'h7F800000, mk(0, 0, 1, 1, 0, 0));
    issue(32'h00000001, 32'h3F800000, mk(0, 0, 0, 0, -149, 64'h2000000));
    issue(32'h7F800000, 32'hFF800000, model(32'h7F800000, 32'hFF800000));
    issue(32'h7FC00000, 32'h3F800000, model(32'h7FC00000, 32'h3F800000));
    issue(32'h7F7FFFFF, 32'h00000001, model(32'h7F7FFFFF, 32'h00000001));
    issue(32'h00000001, 32'h7F7FFFFF, model(32'h00000001, 32'h7F7FFFFF));
    issue(32'h807FFFFF, 32'h00400000, model(32'h807FFFFF, 32'h00400000));

    issue(32'h40490FDB, 32'h3FB504F3, model(32'h40490FDB, 32'h3FB504F3));
    repeat (10) @(negedge clk);
    #3 rst_n = 0;
    #1;
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_d_man", d_man, 0);
    exp_q.delete();
    pending = 0;
    stall = 0;
    release_chk = 0;
    @(negedge clk);
    rst_n = 1;
    issue(32'h40C00000, 32'h40000000, mk(0, 0, 0, 0, 1, 64'h3000000));

    for (int i = 0; i < 200; i++) begin
      x = rand_float();
      y = rand_float();
      if ($urandom_range(0, 7) == 0) stall_next = $urandom_range(1, 4);
      issue(x, y, model(x, y));
    end

    guard = 0;
    while ((exp_q.size() != 0 || pending || !in_ready) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still outstanding", exp_q.size());
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
